// File: rtl/elevator_pkg.sv
// Shared types and constants for the two-car elevator dispatch arbiter.
// Field indices describe the boarding_n and hold_n bit layouts.
package elevator_pkg;

  localparam int NFLOORS = 7;
  localparam logic [1:0] HOLD_CYC = 2'd3;

  typedef logic [2:0] floor_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // boarding_n: pickup floor in [5:3], car-call destination in [2:0]
  localparam int BRD_PICK_LO = 3;
  localparam int BRD_DEST_LO = 0;

  // hold_n: boarding flag/count in [5]/[4:3], alight flag/count in [2]/[1:0]
  localparam int HOLD_B_ON     = 5;
  localparam int HOLD_B_CNT_LO = 3;
  localparam int HOLD_A_ON     = 2;
  localparam int HOLD_A_CNT_LO = 0;

endpackage

// File: rtl/car_hold.sv
// Per-car door-hold timers: boarding and alight holds run independently as
// down-counters that rearm only after reaching zero.
module car_hold
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  floor_t     curr_floor,
  input  logic [5:0] boarding,
  output logic [5:0] hold
);

  floor_t     pick_floor;
  floor_t     dest_floor;
  logic       b_hit;
  logic       a_hit;
  logic [1:0] b_cnt;
  logic [1:0] a_cnt;
  logic       b_on;
  logic       a_on;

  assign pick_floor = boarding[BRD_PICK_LO +: 3];
  assign dest_floor = boarding[BRD_DEST_LO +: 3];
  assign b_hit = (pick_floor != '0) && (curr_floor != '0) && (curr_floor == pick_floor);
  assign a_hit = (dest_floor != '0) && (curr_floor != '0) && (curr_floor == dest_floor);

  // A flag tracks counter != 0 so the hold bits come straight from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      b_cnt <= '0;
      b_on  <= 1'b0;
      a_cnt <= '0;
      a_on  <= 1'b0;
    end else begin
      if (b_cnt == '0 && b_hit) begin
        b_cnt <= HOLD_CYC;
        b_on  <= 1'b1;
      end else if (b_cnt != '0) begin
        b_cnt <= b_cnt - 2'd1;
        b_on  <= (b_cnt != 2'd1);
      end else begin
        b_on  <= 1'b0;
      end

      if (a_cnt == '0 && a_hit) begin
        a_cnt <= HOLD_CYC;
        a_on  <= 1'b1;
      end else if (a_cnt != '0) begin
        a_cnt <= a_cnt - 2'd1;
        a_on  <= (a_cnt != 2'd1);
      end else begin
        a_on  <= 1'b0;
      end
    end
  end

  always_comb begin
    hold = '0;
    hold[HOLD_B_ON]              = b_on;
    hold[HOLD_B_CNT_LO +: 2]     = b_cnt;
    hold[HOLD_A_ON]              = a_on;
    hold[HOLD_A_CNT_LO +: 2]     = a_cnt;
  end

endmodule

// File: rtl/elevator_turn.sv
// Dispatch arbiter for two cars over seven floors: grants turns for pending
// hall calls and raises per-car door holds. All outputs are registered.
module elevator_turn
  import elevator_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  curr_elevator_1,
  input  logic [2:0]  curr_elevator_2,
  input  logic [13:0] up_passenger,
  input  logic [13:0] down_passenger,
  input  logic [1:0]  dir_elevator,
  input  logic [5:0]  boarding_1,
  input  logic [5:0]  boarding_2,
  output logic [1:0]  turn,
  output logic [5:0]  hold_1,
  output logic [5:0]  hold_2
);

  logic       busy_1;
  logic       busy_2;
  logic       elig_1;
  logic       elig_2;
  logic [1:0] turn_nxt;
  floor_t     call_floor;

  car_hold u_hold_1 (
    .clk        (clk),
    .rst        (rst),
    .curr_floor (curr_elevator_1),
    .boarding   (boarding_1),
    .hold       (hold_1)
  );

  car_hold u_hold_2 (
    .clk        (clk),
    .rst        (rst),
    .curr_floor (curr_elevator_2),
    .boarding   (boarding_2),
    .hold       (hold_2)
  );

  assign busy_1 = hold_1[HOLD_B_ON] | hold_1[HOLD_A_ON];
  assign busy_2 = hold_2[HOLD_B_ON] | hold_2[HOLD_A_ON];
  assign elig_1 = !busy_1 && (curr_elevator_1 != '0);
  assign elig_2 = !busy_2 && (curr_elevator_2 != '0);

  function automatic logic [3:0] abs_diff(input floor_t a, input floor_t b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  // Winner for one call: nearest direction-compatible car, else nearest
  // eligible car; distance ties go to car 1.
  function automatic logic [1:0] pick_car(
    input logic   up_call,
    input floor_t f,
    input floor_t fl1,
    input floor_t fl2,
    input logic   dir1,
    input logic   dir2,
    input logic   el1,
    input logic   el2
  );
    logic       c1, c2, k1, k2;
    logic [3:0] d1, d2;
    c1 = el1 && (up_call ? (dir1 == UP && fl1 <= f) : (dir1 == DOWN && fl1 >= f));
    c2 = el2 && (up_call ? (dir2 == UP && fl2 <= f) : (dir2 == DOWN && fl2 >= f));
    k1 = (c1 || c2) ? c1 : el1;
    k2 = (c1 || c2) ? c2 : el2;
    d1 = abs_diff(fl1, f);
    d2 = abs_diff(fl2, f);
    if (k1 && (!k2 || d1 <= d2)) return 2'b01;
    else if (k2)                 return 2'b10;
    else                         return 2'b00;
  endfunction

  always_comb begin
    turn_nxt   = '0;
    call_floor = '0;
    for (int f = 1; f <= NFLOORS; f++) begin
      call_floor = floor_t'(f);
      if (up_passenger[2*f-2 +: 2] != 2'd0)
        turn_nxt = turn_nxt | pick_car(1'b1, call_floor, curr_elevator_1, curr_elevator_2,
                                       dir_elevator[0], dir_elevator[1], elig_1, elig_2);
      if (down_passenger[2*f-2 +: 2] != 2'd0)
        turn_nxt = turn_nxt | pick_car(1'b0, call_floor, curr_elevator_1, curr_elevator_2,
                                       dir_elevator[0], dir_elevator[1], elig_1, elig_2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) turn <= '0;
    else     turn <= turn_nxt;
  end

endmodule

// File: tb/tb_elevator_turn.sv
// Directed-vector bench for elevator_turn with hand-computed expectations.
module tb_elevator_turn;

  logic        clk;
  logic        rst;
  logic [2:0]  curr_elevator_1;
  logic [2:0]  curr_elevator_2;
  logic [13:0] up_passenger;
  logic [13:0] down_passenger;
  logic [1:0]  dir_elevator;
  logic [5:0]  boarding_1;
  logic [5:0]  boarding_2;
  logic [1:0]  turn;
  logic [5:0]  hold_1;
  logic [5:0]  hold_2;

  int n_cmp;
  int n_bad;

  elevator_turn dut (
    .clk             (clk),
    .rst             (rst),
    .curr_elevator_1 (curr_elevator_1),
    .curr_elevator_2 (curr_elevator_2),
    .up_passenger    (up_passenger),
    .down_passenger  (down_passenger),
    .dir_elevator    (dir_elevator),
    .boarding_1      (boarding_1),
    .boarding_2      (boarding_2),
    .turn            (turn),
    .hold_1          (hold_1),
    .hold_2          (hold_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    curr_elevator_1 = 3'd0;
    curr_elevator_2 = 3'd0;
    up_passenger    = '0;
    down_passenger  = '0;
    dir_elevator    = 2'b00;
    boarding_1      = '0;
    boarding_2      = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Reset with arbitrary activity on the inputs
    rst = 1'b1;
    curr_elevator_1 = 3'd3;
    curr_elevator_2 = 3'd2;
    up_passenger    = 14'h3fff;
    down_passenger  = 14'h1234;
    dir_elevator    = 2'b10;
    boarding_1      = 6'b011011;
    boarding_2      = 6'b010010;
    tick();
    tick();
    check("reset_turn", {4'd0, turn}, 6'd0);
    check("reset_hold_1", hold_1, 6'd0);
    check("reset_hold_2", hold_2, 6'd0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // Mixed calls: floor 1 up -> car 1, floor 6 down -> car 2
    curr_elevator_1 = 3'd3;
    curr_elevator_2 = 3'd4;
    dir_elevator    = 2'b01;
    up_passenger    = 14'h0001;
    down_passenger  = 14'b00010000000000;
    boarding_1      = 6'b010111;
    boarding_2      = 6'b110101;
    tick();
    check("mixed_turn", {4'd0, turn}, 6'b000011);
    check("mixed_hold_1", hold_1, 6'd0);
    check("mixed_hold_2", hold_2, 6'd0);

    // Boarding hold on car 1 at floor 2, with a call that car 1 cannot take while held
    clear_inputs();
    curr_elevator_1 = 3'd2;
    curr_elevator_2 = 3'd7;
    boarding_1      = 6'b010000;
    tick();
    check("board_hold_c3", hold_1, 6'b111000);
    up_passenger = 14'h0004;
    tick();
    check("board_hold_c2", hold_1, 6'b110000);
    check("board_turn_c2", {4'd0, turn}, 6'b000010);
    tick();
    check("board_hold_c1", hold_1, 6'b101000);
    check("board_turn_c1", {4'd0, turn}, 6'b000010);
    tick();
    check("board_hold_c0", hold_1, 6'b000000);
    check("board_turn_c0", {4'd0, turn}, 6'b000010);
    tick();
    check("board_hold_rearm", hold_1, 6'b111000);
    check("board_turn_free", {4'd0, turn}, 6'b000001);
    boarding_1   = '0;
    up_passenger = '0;
    tick();
    tick();
    tick();
    check("board_drain", hold_1, 6'd0);

    // Concurrent boarding and alight hold on car 2 at floor 5
    clear_inputs();
    curr_elevator_2 = 3'd5;
    boarding_2      = 6'b101101;
    tick();
    check("both_hold_3", hold_2, 6'b111111);
    boarding_2 = '0;
    tick();
    check("both_hold_2", hold_2, 6'b110110);
    tick();
    check("both_hold_1", hold_2, 6'b101101);
    tick();
    check("both_hold_0", hold_2, 6'b000000);

    // Alight-only hold
    boarding_2 = 6'b000101;
    tick();
    check("alight_hold_3", hold_2, 6'b000111);
    check("alight_other_car", hold_1, 6'b000000);
    boarding_2 = '0;
    tick();
    check("alight_hold_2", hold_2, 6'b000110);
    tick();
    tick();
    check("alight_drain", hold_2, 6'd0);

    // Direction preference beats distance
    clear_inputs();
    curr_elevator_1 = 3'd1;
    curr_elevator_2 = 3'd5;
    dir_elevator    = 2'b01;
    up_passenger    = 14'h0040;
    tick();
    check("dir_pref", {4'd0, turn}, 6'b000001);

    // Down call at 4: only car 2 (at 6, down) is compatible
    clear_inputs();
    curr_elevator_1 = 3'd2;
    curr_elevator_2 = 3'd6;
    dir_elevator    = 2'b00;
    down_passenger  = 14'h0040;
    tick();
    check("compat_down", {4'd0, turn}, 6'b000010);

    // Both cars incompatible, equal distance: car 1 wins
    dir_elevator = 2'b11;
    tick();
    check("tie_car1", {4'd0, turn}, 6'b000001);

    // No pending calls
    down_passenger = '0;
    tick();
    check("no_calls", {4'd0, turn}, 6'b000000);

    // Both cars out of service
    curr_elevator_1 = 3'd0;
    curr_elevator_2 = 3'd0;
    up_passenger    = 14'h0100;
    tick();
    check("out_of_service", {4'd0, turn}, 6'b000000);

    // Top-floor up call with count 3: car 2 (6, up) compatible, car 1 (3, down) not
    clear_inputs();
    curr_elevator_1 = 3'd3;
    curr_elevator_2 = 3'd6;
    dir_elevator    = 2'b10;
    up_passenger    = 14'h3000;
    tick();
    check("top_floor_up", {4'd0, turn}, 6'b000010);

    // Top-floor down call: no one compatible, car 2 nearer
    up_passenger   = '0;
    down_passenger = 14'h1000;
    tick();
    check("top_floor_down", {4'd0, turn}, 6'b000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
